truth_table_driver: RTL

TRUTH_TABLE_DRIVER -- requirements
Module: truth_table_driver

---
 rtl/truth_table_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/truth_table_driver.sv
// truth_table_driver
//   Drives the four input patterns {a,b} = 00, 01, 10, 11 into a downstream
//   gate stage that should return buf_a = a and not_b = ~b. Each pattern is
//   held for HOLD cycles and then sampled for one cycle. The block records
//   which patterns failed and how many failed.
//
// Parameters
//   HOLD       cycles each pattern is driven before it is sampled (1..255)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   start      run request, accepted only in IDLE or DONE
//   abort      synchronous cancel, takes priority over start
//   a, b       registered stimulus to the gate stage
//   buf_a      gate response, expected to equal a
//   not_b      gate response, expected to equal ~b
//   busy       high while a run is in progress
//   done       high once a run completes, held until the next run or abort
//   pass       done with no failing pattern
//   err_count  number of failing patterns in the current or last run (0..4)
//   fail_mask  bit i set when pattern i failed
module truth_table_driver #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  input  logic       buf_a,
  input  logic       not_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The hold counter runs 0..HOLD-1 so that DRIVE lasts exactly HOLD edges.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [7:0] hold_cnt_q;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic [2:0] err_q;
  logic [3:0] mask_q;

  logic       pat_fail_d;
  logic [2:0] err_d;

  // Response check for the pattern currently on a/b.
  assign pat_fail_d = (buf_a != a_q) || (not_b != ~b_q);
  // Saturating increment; with four patterns the ceiling is never exceeded.
  assign err_d      = (err_q < 3'd4) ? err_q + 3'd1 : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 3'd0;
      mask_q     <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (abort) begin
            // Abort wins over start; results of the last run are kept.
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else if (start) begin
            state_q    <= DRIVE;
            idx_q      <= 2'd0;
            hold_cnt_q <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 3'd0;
            mask_q     <= 4'd0;
          end
        end

        DRIVE: begin
          if (abort) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            hold_cnt_q <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= SAMPLE;
            hold_cnt_q <= 8'd0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end

        SAMPLE: begin
          if (abort) begin
            // Cancelled before the compare, so this pattern is not scored.
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            hold_cnt_q <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
          end else begin
            if (pat_fail_d) begin
              mask_q[idx_q] <= 1'b1;
              err_q         <= err_d;
            end
            if (idx_q == 2'd3) begin
              // Last pattern scored; a/b stay at 11.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= DRIVE;
              idx_q      <= idx_q + 2'd1;
              {a_q, b_q} <= idx_q + 2'd1;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          idx_q      <= 2'd0;
          hold_cnt_q <= 8'd0;
          a_q        <= 1'b0;
          b_q        <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_q == 3'd0);
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
